// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isa_pkg
// Purpose  : Opcode constants, instruction field positions and sequencer states
// Revision : 1.0 - initial release
// ============================================================================
package isa_pkg;

  localparam logic [3:0] NOP_OP  = 4'b0000;
  localparam logic [3:0] ALU_OP  = 4'b0001;
  localparam logic [3:0] LD_OP   = 4'b0010;
  localparam logic [3:0] ST_OP   = 4'b0011;
  localparam logic [3:0] BR_OP   = 4'b0100;
  localparam logic [3:0] JMP_OP  = 4'b0101;
  localparam logic [3:0] HALT_OP = 4'b1110;

  localparam int OPC_HI  = 8;
  localparam int OPC_LO  = 5;
  localparam int FMT_HI  = 4;
  localparam int FMT_LO  = 3;
  localparam int IMM_BIT = 2;
  localparam int OPR_HI  = 1;
  localparam int OPR_LO  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_issue_if
// Purpose  : Instruction-memory, issue and redirect signals of the sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_issue_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               issue_valid;
  logic               issue_ready;
  logic [3:0]         opcode;
  logic [1:0]         format;
  logic               imm_flag;
  logic [1:0]         operand;
  logic [PC_W-1:0]    issue_pc;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;

  modport master (
    output imem_req, imem_addr, issue_valid, opcode, format, imm_flag,
           operand, issue_pc,
    input  imem_ack, imem_rdata, issue_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, issue_valid, opcode, format, imm_flag,
           operand, issue_pc,
    output imem_ack, imem_rdata, issue_ready, redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_issue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_issue
// Purpose  : PC owner; fetches instructions over req/ack, issues over valid/ready
// Revision : 1.0 - initial release
// ============================================================================
module fetch_issue
  import isa_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter int              INSTR_W  = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  fetch_issue_if.master      bus,
  output logic               halted,
  output logic [15:0]        issue_count
);

  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] issue_pc_q;
  logic [PC_W-1:0] tgt_q;
  logic            kill_q;
  logic            req_q;
  logic            valid_q;
  logic            halted_q;
  logic [3:0]      opcode_q;
  logic [1:0]      format_q;
  logic            imm_q;
  logic [1:0]      operand_q;
  logic [15:0]     cnt_q;

  logic [PC_W-1:0] pc_inc_d;
  logic            hs_d;

  assign pc_inc_d = pc_q + PC_W'(1);
  assign hs_d     = valid_q && bus.issue_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      issue_pc_q <= RESET_PC;
      tgt_q      <= RESET_PC;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      opcode_q   <= '0;
      format_q   <= '0;
      imm_q      <= 1'b0;
      operand_q  <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end

        FETCH: begin
          if (bus.imem_ack) begin
            if (kill_q || bus.redirect_valid) begin
              // Stale data: drop it and refetch at the newest target.
              kill_q <= 1'b0;
              pc_q   <= bus.redirect_valid ? bus.redirect_pc : tgt_q;
            end else begin
              state_q    <= ISSUE;
              req_q      <= 1'b0;
              valid_q    <= 1'b1;
              issue_pc_q <= pc_q;
              opcode_q   <= bus.imem_rdata[OPC_HI:OPC_LO];
              format_q   <= bus.imem_rdata[FMT_HI:FMT_LO];
              imm_q      <= bus.imem_rdata[IMM_BIT];
              operand_q  <= bus.imem_rdata[OPR_HI:OPR_LO];
            end
          end else if (bus.redirect_valid) begin
            kill_q <= 1'b1;
            tgt_q  <= bus.redirect_pc;
          end
        end

        ISSUE: begin
          if (hs_d) begin
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            valid_q <= 1'b0;
            if (opcode_q == HALT_OP) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= FETCH;
              req_q   <= 1'b1;
              pc_q    <= bus.redirect_valid ? bus.redirect_pc : pc_inc_d;
            end
          end else if (bus.redirect_valid) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            pc_q    <= bus.redirect_pc;
          end
        end

        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.issue_valid = valid_q;
  assign bus.opcode      = opcode_q;
  assign bus.format      = format_q;
  assign bus.imm_flag    = imm_q;
  assign bus.operand     = operand_q;
  assign bus.issue_pc    = issue_pc_q;
  assign halted          = halted_q;
  assign issue_count     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_issue
// Purpose  : Directed cycle-by-cycle checks of the fetch/issue sequencer
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halted;
  logic [15:0] issue_count;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_issue_if #(.PC_W(10), .INSTR_W(9)) bus ();

  fetch_issue #(.PC_W(10), .INSTR_W(9), .RESET_PC(10'h000)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .halted      (halted),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = '0;
    bus.issue_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick();
    tick();
    reset = 1'b0;

    check_eq("rst_req",    32'(bus.imem_req), 0);
    check_eq("rst_valid",  32'(bus.issue_valid), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_count",  32'(issue_count), 0);
    check_eq("rst_addr",   32'(bus.imem_addr), 0);
    check_eq("rst_ipc",    32'(bus.issue_pc), 0);
    check_eq("rst_opc",    32'(bus.opcode), 0);

    // Straight-line fetch
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("sl_req0",  32'(bus.imem_req), 1);
    check_eq("sl_addr0", 32'(bus.imem_addr), 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 9'b0111_00_0_01; bus.issue_ready = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check_eq("sl_valid0", 32'(bus.issue_valid), 1);
    check_eq("sl_req_lo", 32'(bus.imem_req), 0);
    check_eq("sl_opc0",   32'(bus.opcode), 32'h7);
    check_eq("sl_fmt0",   32'(bus.format), 0);
    check_eq("sl_imm0",   32'(bus.imm_flag), 0);
    check_eq("sl_opr0",   32'(bus.operand), 1);
    check_eq("sl_ipc0",   32'(bus.issue_pc), 0);
    tick();
    check_eq("sl_req1",   32'(bus.imem_req), 1);
    check_eq("sl_addr1",  32'(bus.imem_addr), 1);
    check_eq("sl_vlo",    32'(bus.issue_valid), 0);
    check_eq("sl_cnt1",   32'(issue_count), 1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 9'b1000_01_1_10;
    tick();
    bus.imem_ack = 1'b0; bus.issue_ready = 1'b0;
    check_eq("sl_valid1", 32'(bus.issue_valid), 1);
    check_eq("sl_opc1",   32'(bus.opcode), 32'h8);
    check_eq("sl_fmt1",   32'(bus.format), 1);
    check_eq("sl_imm1",   32'(bus.imm_flag), 1);
    check_eq("sl_opr1",   32'(bus.operand), 2);
    check_eq("sl_ipc1",   32'(bus.issue_pc), 1);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_valid", 32'(bus.issue_valid), 1);
      check_eq("bp_req",   32'(bus.imem_req), 0);
      check_eq("bp_opc",   32'(bus.opcode), 32'h8);
      check_eq("bp_ipc",   32'(bus.issue_pc), 1);
    end
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    check_eq("bp_req_on", 32'(bus.imem_req), 1);
    check_eq("bp_addr",   32'(bus.imem_addr), 2);
    check_eq("bp_cnt",    32'(issue_count), 2);
    tick();
    check_eq("bp_addr_hold", 32'(bus.imem_addr), 2);

    // Redirect in ISSUE without handshake
    bus.imem_ack = 1'b1; bus.imem_rdata = 9'b0001_00_0_00;
    tick();
    bus.imem_ack = 1'b0;
    check_eq("sq_valid", 32'(bus.issue_valid), 1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h1F0;
    tick();
    bus.redirect_valid = 1'b0;
    check_eq("sq_vlo",  32'(bus.issue_valid), 0);
    check_eq("sq_req",  32'(bus.imem_req), 1);
    check_eq("sq_addr", 32'(bus.imem_addr), 32'h1F0);
    check_eq("sq_cnt",  32'(issue_count), 2);

    // Redirect during FETCH, ack 3 cycles later
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h020;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("kf_addr_hold", 32'(bus.imem_addr), 32'h1F0);
      check_eq("kf_req_hold",  32'(bus.imem_req), 1);
      tick();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 9'b0010_00_0_00;
    tick();
    bus.imem_ack = 1'b0;
    check_eq("kf_vlo",  32'(bus.issue_valid), 0);
    check_eq("kf_req",  32'(bus.imem_req), 1);
    check_eq("kf_addr", 32'(bus.imem_addr), 32'h020);
    bus.imem_ack = 1'b1; bus.imem_rdata = 9'b0011_00_0_11; bus.issue_ready = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check_eq("kf_valid", 32'(bus.issue_valid), 1);
    check_eq("kf_opc",   32'(bus.opcode), 32'h3);
    check_eq("kf_ipc",   32'(bus.issue_pc), 32'h020);
    tick();
    check_eq("kf_addr2", 32'(bus.imem_addr), 32'h021);
    check_eq("kf_cnt",   32'(issue_count), 3);

    // Redirect coinciding with ack, then PC wrap at 3FF
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h3FF;
    bus.imem_ack = 1'b1; bus.imem_rdata = 9'b0101_00_0_00;
    tick();
    bus.redirect_valid = 1'b0; bus.imem_ack = 1'b0;
    check_eq("ra_vlo",  32'(bus.issue_valid), 0);
    check_eq("ra_addr", 32'(bus.imem_addr), 32'h3FF);
    bus.imem_ack = 1'b1; bus.imem_rdata = 9'b0100_00_0_00;
    tick();
    bus.imem_ack = 1'b0;
    check_eq("wr_ipc", 32'(bus.issue_pc), 32'h3FF);
    tick();
    check_eq("wr_addr", 32'(bus.imem_addr), 0);
    check_eq("wr_cnt",  32'(issue_count), 4);

    // HALT at address 5
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h005; bus.imem_ack = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    check_eq("ht_addr", 32'(bus.imem_addr), 5);
    bus.imem_rdata = 9'b1110_00_0_00;
    tick();
    bus.imem_ack = 1'b0;
    check_eq("ht_opc", 32'(bus.opcode), 32'hE);
    tick();
    check_eq("ht_halted", 32'(halted), 1);
    check_eq("ht_vlo",    32'(bus.issue_valid), 0);
    check_eq("ht_req",    32'(bus.imem_req), 0);
    check_eq("ht_cnt",    32'(issue_count), 5);
    check_eq("ht_pc",     32'(bus.imem_addr), 5);
    start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h100;
    tick();
    start = 1'b0; bus.redirect_valid = 1'b0;
    tick();
    check_eq("ht_req_stay", 32'(bus.imem_req), 0);
    check_eq("ht_hold",     32'(halted), 1);
    check_eq("ht_pc_stay",  32'(bus.imem_addr), 5);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rr_halted", 32'(halted), 0);
    check_eq("rr_req",    32'(bus.imem_req), 0);
    check_eq("rr_cnt",    32'(issue_count), 0);
    check_eq("rr_addr",   32'(bus.imem_addr), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("rr_start", 32'(bus.imem_req), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_issue.md
# fetch_issue

Instruction fetch and issue sequencer that produces the decode-stage inputs (opcode, format, immediate flag) consumed by the control decoder. It owns the program counter, fetches 9-bit instructions from instruction memory over a req/ack handshake, splits each into fields and presents them to the decode/execute stage over a valid/ready handshake. It also accepts branch/jump redirects from execute and stops permanently on HALT.

## Interface
Parameters:
- PC_W, 10, program counter and instruction address width
- INSTR_W, 9, instruction width; field positions fixed as in Operation
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching at current PC
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  PC_W  fetch address; stable while imem_req is high
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle; may coincide with the first req cycle
- imem_rdata  in  INSTR_W  fetched instruction
- issue_valid  out  1  issue fields valid
- issue_ready  in  1  decode/execute accepts the instruction
- opcode  out  4  instr[8:5]
- format  out  2  instr[4:3]
- imm_flag  out  1  instr[2]
- operand  out  2  instr[1:0]
- issue_pc  out  PC_W  address of the issued instruction
- redirect_valid  in  1  branch taken or jump; replaces next PC
- redirect_pc  in  PC_W  redirect target
- halted  out  1  HALT issued; sequencer stopped
- issue_count  out  16  instructions accepted since reset, saturating at 16'hFFFF

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: all outputs inactive. start -> FETCH. redirect_valid is ignored.
- FETCH: imem_req=1, imem_addr=fetch address register. On imem_ack: latch imem_rdata into the instruction register and go to ISSUE.
- ISSUE: issue_valid=1. Fields and issue_pc are held stable until the handshake completes.
  - On valid&&ready with opcode==HALT (4'b1110): go to HALT. halted=1. PC stays at the HALT address.
  - On valid&&ready otherwise: PC <= PC+1, wrapping modulo 2^PC_W. Go to FETCH.
- Redirect priority: redirect_valid overrides PC+1.
  - In ISSUE with the handshake in the same cycle: the instruction counts as issued. Next PC = redirect_pc. Go to FETCH.
  - In ISSUE without the handshake: the instruction is squashed. issue_valid drops next cycle, PC <= redirect_pc, go to FETCH.
  - In FETCH: the outstanding request is not withdrawn; imem_addr stays unchanged. Set the kill flag and record redirect_pc.
  - On the ack of a killed fetch: discard the data and clear the kill flag. The next cycle starts FETCH at the recorded target.
  - redirect_valid arriving together with that ack behaves identically.
- HALT: absorbing until reset. imem_req=0, issue_valid=0, start and redirect are ignored.
- issue_count increments on every valid&&ready handshake, including the HALT handshake.

## Timing
- Reset values:
  - state IDLE; PC and imem_addr RESET_PC.
  - imem_req, issue_valid, halted, kill flag: 0.
  - opcode, format, imm_flag, operand: 0; issue_pc RESET_PC; issue_count 0.
- Reset mid-operation aborts any outstanding fetch; instruction memory tolerates a dropped request.
- All outputs are registered; no combinational input-to-output path.
- start at cycle t -> imem_req=1 at t+1.
- imem_ack at cycle t -> issue_valid=1 at t+1.
- Handshake at cycle t -> imem_req=1 with the new address at t+1.
- Best-case throughput: one instruction per 2 cycles.
- Killed fetch costs one extra memory transaction and issues nothing.

## Structure
- Shared package isa_pkg contains:
  - the 4-bit opcode constants, including HALT_OP=4'b1110;
  - instruction field bit positions;
  - fetch_state_t enum {IDLE, FETCH, ISSUE, HALT}.
- The control decoder imports the same package.
- Single module; no sub-module needed. PC, instruction register, kill flag, redirect-target register and counter are inline.

## Test plan
- Straight-line fetch: reset, start, memory returns 9'b0111_00_0_01 at address 0 and 9'b1000_01_1_10 at address 1, ready=1, ack same cycle -> opcode 4'b0111 then 4'b1000; issue_pc 0 then 1; issue_count 2; issue_valid asserts every 2nd cycle.
- Backpressure: issue_ready=0 for 5 cycles -> issue_valid held and fields stable; no imem_req; then ready=1 -> PC increments exactly once.
- Redirect during ISSUE without handshake, redirect_pc=10'h1F0 -> issue squashed; issue_count unchanged; next imem_addr=10'h1F0.
- Redirect during FETCH with ack delayed 3 cycles, target 10'h020 -> imem_addr unchanged until ack; data discarded; next fetch at 10'h020; no issue from the killed fetch.
- PC wrap: start at 10'h3FF with a non-HALT instruction -> next imem_addr 10'h000.
- HALT: issue 4'b1110 at address 5 -> halted=1 the next cycle; imem_req stays 0 despite start and redirect pulses; reset returns to IDLE with halted=0.
